// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU/HI-LO ops plus an iterative restoring divider
// that stalls upstream for DATA_W cycles.
module ex_muldiv #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int SH_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_i,
    input  logic [4:0]         aluop_i,
    input  logic [DATA_W-1:0]  reg1_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  logic [RADDR_W-1:0] wd_i,
    input  logic               wreg_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic [RADDR_W-1:0] wd_o,
    output logic               wreg_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o
);

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_OR   = 5'd1,  OP_AND  = 5'd2,  OP_XOR  = 5'd3,
        OP_NOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
        OP_ADDU = 5'd8,  OP_SUBU = 5'd9,  OP_SLT  = 5'd10, OP_SLTU = 5'd11,
        OP_MFHI = 5'd12, OP_MFLO = 5'd13, OP_MTHI = 5'd14, OP_MTLO = 5'd15,
        OP_DIV  = 5'd16, OP_DIVU = 5'd17
    } aluop_t;

    typedef enum logic {IDLE, DIV_RUN} state_t;

    state_t state, state_nxt;

    logic [SH_W-1:0]   cnt;
    logic [DATA_W-1:0] rem, quo, dvs;
    logic              neg_q, neg_r, div_zero;

    logic              accept, is_div, signed_div, writes_gpr, last;
    logic [SH_W-1:0]   sh;
    logic [DATA_W-1:0] alu_res, mag_a, mag_b;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff, rem_step, quo_step;
    logic              fits;

    assign stall_o    = (state == DIV_RUN);
    assign accept     = valid_i && (state == IDLE) && !flush_i;
    assign is_div     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign signed_div = (aluop_i == OP_DIV);
    assign writes_gpr = (aluop_i >= OP_OR) && (aluop_i <= OP_MFLO);
    assign last       = (cnt == SH_W'(DATA_W - 1));
    assign sh         = reg1_i[SH_W-1:0];

    assign mag_a = (signed_div && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign mag_b = (signed_div && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

    // One restoring step: the low DATA_W bits of the difference are exact whenever the trial fits.
    assign shifted  = {rem, quo[DATA_W-1]};
    assign fits     = (shifted >= {1'b0, dvs});
    assign diff     = shifted[DATA_W-1:0] - dvs;
    assign rem_step = fits ? diff : shifted[DATA_W-1:0];
    assign quo_step = {quo[DATA_W-2:0], fits};

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_SLL:  alu_res = reg2_i << sh;
            OP_SRL:  alu_res = reg2_i >> sh;
            OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> sh);
            OP_ADDU: alu_res = reg1_i + reg2_i;
            OP_SUBU: alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res = DATA_W'($signed(reg1_i) < $signed(reg2_i));
            OP_SLTU: alu_res = DATA_W'(reg1_i < reg2_i);
            OP_MFHI: alu_res = hi_o;
            OP_MFLO: alu_res = lo_o;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_div) state_nxt = DIV_RUN;
            DIV_RUN: if (flush_i || last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o  <= 1'b0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            wdata_o  <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    valid_o <= !is_div;
                    wreg_o  <= wreg_i && writes_gpr;
                    wd_o    <= wd_i;
                    wdata_o <= alu_res;
                    if (aluop_i == OP_MTHI) hi_o <= reg1_i;
                    if (aluop_i == OP_MTLO) lo_o <= reg1_i;
                    if (is_div) begin
                        rem      <= '0;
                        quo      <= mag_a;
                        dvs      <= mag_b;
                        cnt      <= '0;
                        neg_q    <= signed_div && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        neg_r    <= signed_div && reg1_i[DATA_W-1];
                        div_zero <= (reg2_i == '0);
                    end
                end
            end else if (!flush_i) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 1'b1;
                if (last) begin
                    valid_o <= 1'b1;
                    lo_o    <= div_zero ? '1 : (neg_q ? -quo_step : quo_step);
                    hi_o    <= neg_r ? -rem_step : rem_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, valid_i, wreg_i, flush_i;
    logic [4:0]    aluop_i, wd_i;
    logic [W-1:0]  reg1_i, reg2_i;
    logic          stall_o, valid_o, wreg_o;
    logic [4:0]    wd_o;
    logic [W-1:0]  wdata_o, hi_o, lo_o;

    ex_muldiv #(.DATA_W(W), .RADDR_W(5), .SH_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] ref_res(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s = a[4:0];
        case (op)
            1:  return a | b;
            2:  return a & b;
            3:  return a ^ b;
            4:  return ~(a | b);
            5:  return b << s;
            6:  return b >> s;
            7:  return (b >> s) | (b[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            8:  return a + b;
            9:  return a - b;
            10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            11: return (a < b) ? 32'd1 : 32'd0;
            12: return m_hi;
            13: return m_lo;
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_div(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == 0) begin
            q = '1; r = a;
        end else if (op == 16) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] wd, input logic wreg);
        valid_i = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
    endtask

    // Called just after the edge that accepted a single-cycle op.
    task automatic expect_single(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] wd, input logic wreg);
        logic [W-1:0] exp_d = ref_res(op, a, b);
        logic exp_w = (op >= 1 && op <= 13) ? wreg : 1'b0;
        check($sformatf("op%0d valid", op), W'(valid_o), 1);
        check($sformatf("op%0d wreg", op), W'(wreg_o), W'(exp_w));
        check($sformatf("op%0d wd", op), W'(wd_o), W'(wd));
        if (op != 14 && op != 15) check($sformatf("op%0d wdata", op), wdata_o, exp_d);
        if (op == 14) m_hi = a;
        if (op == 15) m_lo = a;
        check($sformatf("op%0d hi", op), hi_o, m_hi);
        check($sformatf("op%0d lo", op), lo_o, m_lo);
    endtask

    task automatic single(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] wd, input logic wreg);
        drive(op, a, b, wd, wreg);
        @(posedge clk); #1;
        valid_i = 1'b0;
        expect_single(op, a, b, wd, wreg);
    endtask

    // Divide, optionally with an op held on the inputs behind it.
    task automatic divide(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic f_valid, input logic [4:0] f_op,
                          input logic [W-1:0] f_a, input logic [W-1:0] f_b);
        int unsigned n = 0;
        logic stray = 1'b0;
        logic [W-1:0] q, r;
        drive(op, a, b, 5'd9, 1'b1);
        @(posedge clk); #1;
        valid_i = f_valid;
        if (f_valid) drive(f_op, f_a, f_b, 5'd7, 1'b1);
        while (stall_o && n < 100) begin
            if (valid_o) stray = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        ref_div(op, a, b, q, r);
        m_lo = q; m_hi = r;
        check("div stall cycles", n, W);
        check("div early valid", W'(stray), 0);
        check("div done valid", W'(valid_o), 1);
        check("div done wreg", W'(wreg_o), 0);
        check($sformatf("div lo %h/%h", a, b), lo_o, m_lo);
        check($sformatf("div hi %h/%h", a, b), hi_o, m_hi);
        if (f_valid) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            expect_single(f_op, f_a, f_b, 5'd7, 1'b1);
        end
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 40);
            1:       return edges[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] fops [4] = '{5'd0, 5'd12, 5'd13, 5'd8};
        rst = 1'b1; valid_i = 0; flush_i = 0; aluop_i = 0; reg1_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst valid", W'(valid_o), 0);
        check("rst wreg", W'(wreg_o), 0);
        check("rst wdata", wdata_o, 0);
        check("rst wd", W'(wd_o), 0);
        check("rst stall", W'(stall_o), 0);
        check("rst hi", hi_o, 0);
        check("rst lo", lo_o, 0);
        rst = 1'b0;

        single(5'd1, 32'h0F0F_0000, 32'h0000_00FF, 5'd3, 1'b1);
        check("or exact", wdata_o, 32'h0F0F_00FF);
        single(5'd7, 32'd4, 32'h8000_0000, 5'd4, 1'b1);
        check("sra exact", wdata_o, 32'hF800_0000);
        single(5'd10, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        check("slt exact", wdata_o, 32'd1);
        single(5'd11, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        check("sltu exact", wdata_o, 32'd0);
        single(5'd0, 32'h1234, 32'h5678, 5'd6, 1'b1);

        divide(5'd16, 32'd7, 32'hFFFF_FFFE, 1'b1, 5'd13, 0, 0);
        check("div 7/-2 mflo", wdata_o, 32'hFFFF_FFFD);
        divide(5'd17, 32'h10, 32'h0, 1'b0, 0, 0, 0);
        divide(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        divide(5'd16, 32'hFFFF_FFF9, 32'h0, 1'b1, 5'd12, 0, 0);

        // Flushed op in IDLE must leave no trace.
        drive(5'd14, 32'hDEAD, 0, 5'd1, 1'b1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 0; flush_i = 0;
        check("idle flush valid", W'(valid_o), 0);
        check("idle flush wreg", W'(wreg_o), 0);
        check("idle flush hi", hi_o, m_hi);

        single(5'd14, 32'h55, 0, 5'd1, 1'b1);
        drive(5'd17, 32'd100, 32'd7, 5'd2, 1'b1);
        @(posedge clk); #1;
        valid_i = 0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush stall", W'(stall_o), 0);
        check("flush valid", W'(valid_o), 0);
        check("flush hi", hi_o, 32'h55);
        check("flush lo", lo_o, m_lo);
        @(posedge clk); #1;
        check("flush no late valid", W'(valid_o), 0);

        drive(5'd16, 32'd1000, 32'd3, 5'd2, 1'b1);
        @(posedge clk); #1;
        valid_i = 0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 0; m_lo = 0;
        check("mid rst valid", W'(valid_o), 0);
        check("mid rst wreg", W'(wreg_o), 0);
        check("mid rst wdata", wdata_o, 0);
        check("mid rst stall", W'(stall_o), 0);
        check("mid rst hi", hi_o, 0);
        check("mid rst lo", lo_o, 0);
        single(5'd8, 32'hFFFF_FFFF, 32'd2, 5'd8, 1'b1);
        check("addu wrap", wdata_o, 32'd1);

        for (int i = 0; i < 300; i++) begin
            int unsigned kind = $urandom_range(0, 15);
            logic [4:0] op = 5'($urandom_range(0, 31));
            if (kind == 0) begin
                divide(5'($urandom_range(16, 17)), rand_val(), rand_val(),
                       1'($urandom_range(0, 1)), fops[$urandom_range(0, 3)], rand_val(), rand_val());
            end else if (kind == 1) begin
                drive(op, rand_val(), rand_val(), 5'($urandom), 1'b1);
                flush_i = 1'b1;
                @(posedge clk); #1;
                valid_i = 0; flush_i = 0;
                check("rand flush valid", W'(valid_o), 0);
                check("rand flush hi", hi_o, m_hi);
                check("rand flush lo", lo_o, m_lo);
            end else if (kind == 2) begin
                @(posedge clk); #1;
                check("rand idle valid", W'(valid_o), 0);
                check("rand idle wreg", W'(wreg_o), 0);
            end else begin
                if (op == 16 || op == 17) op = 5'd8;
                single(op, rand_val(), rand_val(), 5'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
